// File: rtl/bus8085_pkg.sv
// bus8085_pkg
// Shared definitions for the 8085-style CPU bus: data/address widths,
// S1/S0 status encodings and the responder state type.
// No ports (package).
package bus8085_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  // S1,S0 status encodings as driven by the CPU.
  localparam logic [1:0] ST_FETCH = 2'b11;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b00;

  // Responder FSM encodings, kept explicit so they stay stable for legacy tools.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2,
    WRITE = 2'd3
  } resp_state_t;

endpackage

// File: rtl/resp_ram.sv
// resp_ram
// Single-port RAM, 2^ADDR_BITS x DATA_W. Synchronous write, combinational
// read of an address that the caller already holds in a register.
// No reset: contents survive a bus reset.
// Ports:
//   clock - write clock
//   addr  - registered word index
//   we    - write enable, sampled on posedge clock
//   wdata - write data
//   rdata - mem[addr]
module resp_ram
  import bus8085_pkg::*;
#(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clock,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder
// Memory-side target for the 8085-style bus. Answers opcode fetch, memory
// read and memory write cycles that fall inside a 2^ADDR_BITS byte window
// at ADDR_BASE. It holds READY low for WAIT_CYCLES clocks per claimed cycle.
// Optional feature macro: IO_SPACE_EN. When it is defined, an 8-bit io_reg
// also answers IO cycles addressed to IO_PORT. When it is undefined, every
// IO cycle is a miss.
// Ports:
//   clock    - single clock, posedge
//   reset_in - synchronous active-low reset
//   ADD      - CPU address
//   DATA     - shared data bus, driven only while answering a read
//   S0, S1   - CPU status
//   IO_Mn    - 1 = IO cycle, 0 = memory cycle
//   RDn, WRn - active-low strobes
//   READY    - 0 requests a wait state
//   bus_err  - one-clock pulse when RDn and WRn are first seen low together
module bus_mem_responder
  import bus8085_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 16'h0000,
  parameter int                ADDR_BITS   = 11,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [7:0]        IO_PORT     = 8'h10
) (
  input  logic              clock,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] ADD,
  inout  wire  [DATA_W-1:0] DATA,
  input  logic              S0,
  input  logic              S1,
  input  logic              IO_Mn,
  input  logic              RDn,
  input  logic              WRn,
  output logic              READY,
  output logic              bus_err
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_CYCLES);

  resp_state_t           state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  logic                  is_wr_reg, is_wr_next;
  logic                  is_io_reg, is_io_next;
  logic                  ready_reg, ready_next;
  logic                  drive_reg, drive_next;
  logic                  err_reg, err_next;
  logic                  rd_prev_reg, wr_prev_reg;
  logic [DATA_W-1:0]     data_prev_reg;
  logic                  ram_we, io_we;
  logic                  mem_hit, io_hit, hit;
  logic                  rd_fall, wr_fall, both_low;
  logic [DATA_W-1:0]     ram_rdata, rdata;

  assign mem_hit  = ~IO_Mn && (ADD[ADDR_W-1:ADDR_BITS] == ADDR_BASE[ADDR_W-1:ADDR_BITS]);
  assign hit      = mem_hit | io_hit;
  assign rd_fall  = rd_prev_reg & ~RDn;
  assign wr_fall  = wr_prev_reg & ~WRn;
  assign both_low = ~RDn & ~WRn;

`ifdef IO_SPACE_EN
  logic [DATA_W-1:0] io_reg;

  assign io_hit = IO_Mn && (ADD[7:0] == IO_PORT);
  assign rdata  = is_io_reg ? io_reg : ram_rdata;

  always_ff @(posedge clock) begin
    if (!reset_in) begin
      io_reg <= '0;
    end else if (io_we) begin
      io_reg <= data_prev_reg;
    end
  end
`else
  logic unused_io_port;

  assign io_hit         = 1'b0;
  assign rdata          = ram_rdata;
  assign unused_io_port = ^{IO_PORT, io_we, is_io_reg};
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    is_wr_next = is_wr_reg;
    is_io_next = is_io_reg;
    ready_next = ready_reg;
    drive_next = drive_reg;
    err_next   = 1'b0;
    ram_we     = 1'b0;
    io_we      = 1'b0;

    if (both_low) begin
      // Abandon the cycle. Flag it only on the first clock of the overlap.
      state_next = IDLE;
      cnt_next   = '0;
      ready_next = 1'b1;
      drive_next = 1'b0;
      err_next   = rd_prev_reg | wr_prev_reg;
    end else begin
      case (state_reg)
        IDLE: begin
          if ((rd_fall && hit && S1) || (wr_fall && hit && ({S1, S0} == ST_WRITE))) begin
            addr_next  = ADD[ADDR_BITS-1:0];
            is_wr_next = ~rd_fall;
            is_io_next = io_hit;
            cnt_next   = '0;
            if (WAIT_LIM == 8'd0) begin
              state_next = rd_fall ? DRIVE : WRITE;
              ready_next = 1'b1;
              drive_next = rd_fall;
            end else begin
              state_next = WAIT;
              ready_next = 1'b0;
            end
          end
        end
        WAIT: begin
          if (is_wr_reg ? WRn : RDn) begin
            // Strobe withdrawn before the wait finished: drop the cycle.
            state_next = IDLE;
            cnt_next   = '0;
            ready_next = 1'b1;
          end else begin
            cnt_next = 8'(cnt_reg + 8'd1);
            if (8'(cnt_reg + 8'd1) == WAIT_LIM) begin
              state_next = is_wr_reg ? WRITE : DRIVE;
              ready_next = 1'b1;
              drive_next = ~is_wr_reg;
            end
          end
        end
        DRIVE: begin
          if (RDn) begin
            state_next = IDLE;
            drive_next = 1'b0;
          end
        end
        WRITE: begin
          // Commit on the WRn rising sample, using data captured one clock earlier.
          if (WRn) begin
            state_next = IDLE;
            cnt_next   = '0;
            ram_we     = ~is_io_reg;
            io_we      = is_io_reg;
          end
        end
        default: begin
          state_next = IDLE;
          ready_next = 1'b1;
          drive_next = 1'b0;
        end
      endcase
    end

    // Reset wins over a pending commit in the same edge.
    if (!reset_in) begin
      ram_we = 1'b0;
      io_we  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_in) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      is_wr_reg     <= 1'b0;
      is_io_reg     <= 1'b0;
      ready_reg     <= 1'b1;
      drive_reg     <= 1'b0;
      err_reg       <= 1'b0;
      rd_prev_reg   <= 1'b1;
      wr_prev_reg   <= 1'b1;
      data_prev_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      is_wr_reg     <= is_wr_next;
      is_io_reg     <= is_io_next;
      ready_reg     <= ready_next;
      drive_reg     <= drive_next;
      err_reg       <= err_next;
      rd_prev_reg   <= RDn;
      wr_prev_reg   <= WRn;
      data_prev_reg <= DATA;
    end
  end

  resp_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clock(clock),
    .addr (addr_reg),
    .we   (ram_we),
    .wdata(data_prev_reg),
    .rdata(ram_rdata)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data_drv
      assign DATA[gi] = drive_reg ? rdata[gi] : 1'bz;
    end
  endgenerate

  assign READY   = ready_reg;
  assign bus_err = err_reg;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder
// Directed bench. Two responders share the CPU signals. dut uses one wait
// state and dut0 uses zero. Each has its own pulled-up data net, so a
// released bus reads 8'hFF. Test data therefore never uses 8'hFF.
module tb_bus_mem_responder;

  logic        clock = 1'b0;
  logic        reset_in;
  logic [15:0] ADD;
  logic        S0, S1, IO_Mn, RDn, WRn;
  logic        ready1, ready0, err1, err0;
  tri1  [7:0]  data1;
  tri1  [7:0]  data0;
  logic        drv_en;
  logic [7:0]  drv_val;

  int errors = 0;
  int checks = 0;

  assign data1 = drv_en ? drv_val : 8'bz;
  assign data0 = drv_en ? drv_val : 8'bz;

  always #5 clock = ~clock;

  bus_mem_responder #(.WAIT_CYCLES(1)) dut (
    .clock(clock), .reset_in(reset_in), .ADD(ADD), .DATA(data1),
    .S0(S0), .S1(S1), .IO_Mn(IO_Mn), .RDn(RDn), .WRn(WRn),
    .READY(ready1), .bus_err(err1)
  );

  bus_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_in(reset_in), .ADD(ADD), .DATA(data0),
    .S0(S0), .S1(S1), .IO_Mn(IO_Mn), .RDn(RDn), .WRn(WRn),
    .READY(ready0), .bus_err(err0)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    ADD = a; S1 = 1'b0; S0 = 1'b1; drv_val = v; drv_en = 1'b1; WRn = 1'b0;
    tick(); tick();
    WRn = 1'b1;
    tick();
    drv_en = 1'b0; S0 = 1'b0;
    tick();
  endtask

  // v0 is taken at the first edge (zero-wait), v1 one edge later.
  task automatic bus_read(input logic [15:0] a, output logic [7:0] v1, output logic [7:0] v0);
    ADD = a; S1 = 1'b1; S0 = 1'b0; RDn = 1'b0;
    tick();
    v0 = data0;
    tick();
    v1 = data1;
    RDn = 1'b1;
    tick();
    S1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    tick(); tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b exp=1", ready0); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err1); end
    checks++; if (data1 !== 8'hFF) begin errors++; $display("FAIL reset_data1 got=%h exp=released", data1); end
    reset_in = 1'b1;
    tick();
    $display("reset: ready1=%b ready0=%b err=%b data1=%h", ready1, ready0, err1, data1);
  endtask

  task automatic test_fetch();
    bus_write(16'h0502, 8'h3E);
    ADD = 16'h0502; S1 = 1'b1; S0 = 1'b1; RDn = 1'b0;
    tick();
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL fetch_wait_ready got=%b exp=0", ready1); end
    checks++; if (data1 !== 8'hFF) begin errors++; $display("FAIL fetch_wait_data got=%h exp=released", data1); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL fetch_zw_ready got=%b exp=1", ready0); end
    checks++; if (data0 !== 8'h3E) begin errors++; $display("FAIL fetch_zw_data got=%h exp=3e", data0); end
    tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL fetch_ready got=%b exp=1", ready1); end
    checks++; if (data1 !== 8'h3E) begin errors++; $display("FAIL fetch_data got=%h exp=3e", data1); end
    RDn = 1'b1;
    tick();
    checks++; if (data1 !== 8'hFF) begin errors++; $display("FAIL fetch_release got=%h exp=released", data1); end
    S1 = 1'b0; S0 = 1'b0;
    tick();
    $display("fetch 0502: data=3e checked");
  endtask

  task automatic test_write_read();
    logic [7:0] v1, v0;
    ADD = 16'h0010; S1 = 1'b0; S0 = 1'b1; drv_val = 8'hA5; drv_en = 1'b1; WRn = 1'b0;
    tick();
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL wr_wait_ready got=%b exp=0", ready1); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL wr_zw_ready got=%b exp=1", ready0); end
    tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", ready1); end
    WRn = 1'b1;
    tick();
    drv_en = 1'b0; S0 = 1'b0;
    tick();
    bus_read(16'h0010, v1, v0);
    checks++; if (v1 !== 8'hA5) begin errors++; $display("FAIL rd_0010 got=%h exp=a5", v1); end
    checks++; if (v0 !== 8'hA5) begin errors++; $display("FAIL rd_0010_zw got=%h exp=a5", v0); end
    $display("write/read 0010: v1=%h v0=%h", v1, v0);
  endtask

  task automatic test_miss();
    ADD = 16'h4000; S1 = 1'b1; S0 = 1'b0; RDn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ready1 !== 1'b1 || ready0 !== 1'b1) begin errors++; $display("FAIL miss_ready got=%b%b exp=11", ready1, ready0); end
      checks++; if (data1 !== 8'hFF || data0 !== 8'hFF) begin errors++; $display("FAIL miss_data got=%h/%h exp=released", data1, data0); end
    end
    RDn = 1'b1;
    tick();
`ifndef IO_SPACE_EN
    IO_Mn = 1'b1; ADD = 16'h0010; RDn = 1'b0;
    tick(); tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL io_miss_ready got=%b exp=1", ready1); end
    checks++; if (data1 !== 8'hFF || data0 !== 8'hFF) begin errors++; $display("FAIL io_miss_data got=%h/%h exp=released", data1, data0); end
    RDn = 1'b1;
    tick();
    IO_Mn = 1'b0;
`endif
    S1 = 1'b0;
    tick();
    $display("miss 4000 and io: checked");
  endtask

  task automatic test_bus_err();
    logic [7:0] v1, v0;
    ADD = 16'h0010; S1 = 1'b0; S0 = 1'b1; drv_val = 8'h77; drv_en = 1'b1; WRn = 1'b0;
    tick();
    drv_en = 1'b0; RDn = 1'b0;
    tick();
    checks++; if (err1 !== 1'b1 || err0 !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b%b exp=11", err1, err0); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL err_ready got=%b exp=1", ready1); end
    checks++; if (data1 !== 8'hFF) begin errors++; $display("FAIL err_data got=%h exp=released", data1); end
    tick();
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL err_one_clock got=%b exp=0", err1); end
    RDn = 1'b1; WRn = 1'b1;
    tick();
    S0 = 1'b0;
    tick();
    bus_read(16'h0010, v1, v0);
    checks++; if (v1 !== 8'hA5 || v0 !== 8'hA5) begin errors++; $display("FAIL err_ram got=%h/%h exp=a5", v1, v0); end
    $display("bus_err: ram 0010=%h", v1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v1, v0;
    ADD = 16'h0502; S1 = 1'b1; S0 = 1'b0; RDn = 1'b0;
    tick(); tick();
    reset_in = 1'b0;
    tick();
    checks++; if (data1 !== 8'hFF || data0 !== 8'hFF) begin errors++; $display("FAIL rst_mid_data got=%h/%h exp=released", data1, data0); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready1); end
    reset_in = 1'b1; RDn = 1'b1; S1 = 1'b0;
    tick();
    bus_read(16'h0502, v1, v0);
    checks++; if (v1 !== 8'h3E) begin errors++; $display("FAIL rst_mid_ram got=%h exp=3e", v1); end
    $display("reset mid-drive: ram 0502=%h", v1);
  endtask

  task automatic test_boundary();
    logic [7:0] v1, v0;
    bus_write(16'h07FF, 8'h5A);
    bus_write(16'h0000, 8'hC3);
    bus_write(16'h0800, 8'h11);
    bus_read(16'h07FF, v1, v0);
    checks++; if (v1 !== 8'h5A) begin errors++; $display("FAIL top_byte got=%h exp=5a", v1); end
    bus_read(16'h0000, v1, v0);
    checks++; if (v1 !== 8'hC3) begin errors++; $display("FAIL no_alias got=%h exp=c3", v1); end
    bus_read(16'h0800, v1, v0);
    checks++; if (v1 !== 8'hFF || v0 !== 8'hFF) begin errors++; $display("FAIL above_window got=%h/%h exp=released", v1, v0); end
    $display("boundary: 07ff/0000/0800 checked");
  endtask

`ifdef IO_SPACE_EN
  task automatic test_io();
    logic [7:0] v1, v0;
    IO_Mn = 1'b1;
    bus_write(16'h0010, 8'h5C);
    bus_read(16'h0010, v1, v0);
    checks++; if (v1 !== 8'h5C) begin errors++; $display("FAIL io_rd got=%h exp=5c", v1); end
    bus_read(16'h0011, v1, v0);
    checks++; if (v1 !== 8'hFF) begin errors++; $display("FAIL io_miss got=%h exp=released", v1); end
    IO_Mn = 1'b0;
    $display("io port 10: checked");
  endtask
`endif

  initial begin
    reset_in = 1'b0; ADD = '0; S0 = 1'b0; S1 = 1'b0; IO_Mn = 1'b0;
    RDn = 1'b1; WRn = 1'b1; drv_en = 1'b0; drv_val = '0;
    test_reset();
    test_fetch();
    test_write_read();
    test_miss();
    test_bus_err();
    test_reset_mid();
    test_boundary();
`ifdef IO_SPACE_EN
    test_io();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
